// File: rtl/inner_write_request_issuer_if.sv
// ----------------------------------------------------------------------------
// inner_write_request_issuer_if
//   Bundles the command, source-beat and inner AW/W channel signals of the
//   inner write request issuer.
//
//   master : the issuer. It accepts commands and source beats and drives the
//            inner AW/W channel, CMD_DONE and BUSY.
//   slave  : the environment. It supplies commands and source beats and
//            provides the inner AW/W ready signals.
//
//   CMD_*    command address/length handshake (CMD_LEN = beats - 1)
//   SRC_*    raw data-beat stream handshake
//   INNER_*  inner write-channel AW and W signals
//   CMD_DONE one-cycle pulse after the last beat of a command is accepted
//   BUSY     any command still pending on AW or W
// ----------------------------------------------------------------------------
interface inner_write_request_issuer_if #(
  parameter int AddressWidth       = 32,
  parameter int DataWidth          = 32,
  parameter int InnerIFLengthWidth = 16
);
  logic [AddressWidth-1:0]       CMD_ADDR;
  logic [InnerIFLengthWidth-1:0] CMD_LEN;
  logic                          CMD_VALID;
  logic                          CMD_READY;

  logic [DataWidth-1:0]          SRC_DATA;
  logic                          SRC_VALID;
  logic                          SRC_READY;

  logic [AddressWidth-1:0]       INNER_AWADDR;
  logic [InnerIFLengthWidth-1:0] INNER_AWLEN;
  logic                          INNER_AWVALID;
  logic                          INNER_AWREADY;

  logic [DataWidth-1:0]          INNER_WDATA;
  logic                          INNER_WLAST;
  logic                          INNER_WVALID;
  logic                          INNER_WREADY;

  logic                          CMD_DONE;
  logic                          BUSY;

  modport master (
    input  CMD_ADDR, CMD_LEN, CMD_VALID,
    output CMD_READY,
    input  SRC_DATA, SRC_VALID,
    output SRC_READY,
    output INNER_AWADDR, INNER_AWLEN, INNER_AWVALID,
    input  INNER_AWREADY,
    output INNER_WDATA, INNER_WLAST, INNER_WVALID,
    input  INNER_WREADY,
    output CMD_DONE, BUSY
  );

  modport slave (
    output CMD_ADDR, CMD_LEN, CMD_VALID,
    input  CMD_READY,
    output SRC_DATA, SRC_VALID,
    input  SRC_READY,
    input  INNER_AWADDR, INNER_AWLEN, INNER_AWVALID,
    output INNER_AWREADY,
    input  INNER_WDATA, INNER_WLAST, INNER_WVALID,
    output INNER_WREADY,
    input  CMD_DONE, BUSY
  );
endinterface

// File: rtl/inner_write_request_issuer.sv
// ----------------------------------------------------------------------------
// inner_write_request_issuer
//   Upstream feeder for an AXI4 master write channel. Commands (address +
//   beat count) pass through a single AW register slice; each accepted
//   command's length is also pushed into a small length queue. The raw
//   source beat stream is passed combinationally to the W channel and framed
//   into bursts by comparing a beat counter against the queue head, which
//   produces INNER_WLAST. Up to 2^LenQDepthLog2 commands may run ahead of
//   their data.
//
//   Ports:
//     ACLK    clock
//     ARESETN asynchronous active-low reset; discards all pending work
//     bus     master side of inner_write_request_issuer_if (command, source
//             beat and inner AW/W signals, CMD_DONE, BUSY)
//
//   LenQDepthLog2 must be at least 1.
// ----------------------------------------------------------------------------
module inner_write_request_issuer #(
  parameter int AddressWidth       = 32,
  parameter int DataWidth          = 32,
  parameter int InnerIFLengthWidth = 16,
  parameter int LenQDepthLog2      = 2
) (
  input  logic                         ACLK,
  input  logic                         ARESETN,
  inner_write_request_issuer_if.master bus
);

  localparam int Depth = 1 << LenQDepthLog2;

  typedef logic [InnerIFLengthWidth-1:0] len_t;
  typedef logic [AddressWidth-1:0]       addr_t;
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  typedef logic [LenQDepthLog2:0]        ptr_t;

  // AW register slice
  logic  aw_valid_q, aw_valid_d;
  addr_t aw_addr_q,  aw_addr_d;
  len_t  aw_len_q,   aw_len_d;

  // Length queue
  len_t  len_mem_q [Depth];
  len_t  len_mem_d [Depth];
  ptr_t  wr_ptr_q, wr_ptr_d;
  ptr_t  rd_ptr_q, rd_ptr_d;

  // W framing
  len_t  beat_cnt_q, beat_cnt_d;
  logic  cmd_done_q, cmd_done_d;

  logic  lenq_empty;
  logic  lenq_full;
  len_t  lenq_head;
  logic  cmd_ready;
  logic  cmd_accept;
  logic  w_valid;
  logic  w_last;
  logic  w_handshake;
  logic  last_handshake;

  assign lenq_empty = (wr_ptr_q == rd_ptr_q);
  assign lenq_full  = ((wr_ptr_q - rd_ptr_q) == ptr_t'(Depth));
  assign lenq_head  = len_mem_q[rd_ptr_q[LenQDepthLog2-1:0]];

  // Fullness is judged on the registered pointers only, so a pop in the same
  // cycle does not open a slot until the next cycle.
  assign cmd_ready  = (!aw_valid_q || bus.INNER_AWREADY) && !lenq_full;
  assign cmd_accept = bus.CMD_VALID && cmd_ready;

  assign w_valid        = bus.SRC_VALID && !lenq_empty;
  assign w_last         = !lenq_empty && (beat_cnt_q == lenq_head);
  assign w_handshake    = w_valid && bus.INNER_WREADY;
  assign last_handshake = w_handshake && w_last;

  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    aw_valid_d = aw_valid_q;
    aw_addr_d  = aw_addr_q;
    aw_len_d   = aw_len_q;
    len_mem_d  = len_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    beat_cnt_d = beat_cnt_q;
    cmd_done_d = last_handshake;

    if (cmd_accept) begin
      aw_addr_d  = bus.CMD_ADDR;
      aw_len_d   = bus.CMD_LEN;
      aw_valid_d = 1'b1;
      len_mem_d[wr_ptr_q[LenQDepthLog2-1:0]] = bus.CMD_LEN;
      wr_ptr_d   = wr_ptr_q + ptr_t'(1);
    end else if (bus.INNER_AWREADY) begin
      aw_valid_d = 1'b0;
    end

    // The counter stops at the head value because WLAST fires there, so a
    // maximum-length burst reaches all-ones without wrapping.
    if (last_handshake) begin
      beat_cnt_d = '0;
      rd_ptr_d   = rd_ptr_q + ptr_t'(1);
    end else if (w_handshake) begin
      beat_cnt_d = beat_cnt_q + len_t'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values computed before this edge, independent of statement order.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_valid_q <= 1'b0;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      beat_cnt_q <= '0;
      cmd_done_q <= 1'b0;
      // NOTE: the queue storage is a handful of flops, so it is cleared with
      // the pointers; a large RAM-backed queue would rely on the pointers
      // alone and leave its storage unreset.
      for (int i = 0; i < Depth; i++) begin
        len_mem_q[i] <= '0;
      end
    end else begin
      aw_valid_q <= aw_valid_d;
      aw_addr_q  <= aw_addr_d;
      aw_len_q   <= aw_len_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      cmd_done_q <= cmd_done_d;
      len_mem_q  <= len_mem_d;
    end
  end

  assign bus.CMD_READY     = cmd_ready;
  assign bus.INNER_AWADDR  = aw_addr_q;
  assign bus.INNER_AWLEN   = aw_len_q;
  assign bus.INNER_AWVALID = aw_valid_q;
  assign bus.INNER_WDATA   = bus.SRC_DATA;
  assign bus.INNER_WVALID  = w_valid;
  assign bus.INNER_WLAST   = w_last;
  assign bus.SRC_READY     = bus.INNER_WREADY && !lenq_empty;
  assign bus.CMD_DONE      = cmd_done_q;
  assign bus.BUSY          = aw_valid_q || !lenq_empty;

endmodule

// File: tb/tb_inner_write_request_issuer.sv
// ----------------------------------------------------------------------------
// tb_inner_write_request_issuer
//   Directed scenarios with randomized source data and valid patterns. A
//   behavioural reference model (a pending-command record and a queue of
//   outstanding burst lengths) predicts every DUT output each cycle.
// ----------------------------------------------------------------------------
module tb_inner_write_request_issuer;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int LW    = 16;
  localparam int QL2   = 2;
  localparam int QSIZE = 1 << QL2;

  logic ACLK    = 1'b0;
  logic ARESETN = 1'b0;

  always #5 ACLK = ~ACLK;

  inner_write_request_issuer_if #(
    .AddressWidth(AW), .DataWidth(DW), .InnerIFLengthWidth(LW)
  ) bus ();

  inner_write_request_issuer #(
    .AddressWidth(AW), .DataWidth(DW), .InnerIFLengthWidth(LW),
    .LenQDepthLog2(QL2)
  ) dut (
    .ACLK(ACLK),
    .ARESETN(ARESETN),
    .bus(bus)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
  } cmd_t;

  int checks = 0;
  int errors = 0;

  // Stimulus state
  cmd_t          cmd_src_q[$];
  logic [DW-1:0] preset_q[$];
  logic [DW-1:0] exp_data_q[$];
  bit            src_en;
  int            src_pct;
  bit            src_have;
  logic [DW-1:0] src_cur;
  bit            awready_val;
  int            wready_mode;   // 0 = low, 1 = high, 2 = toggling
  int            cyc;

  // Reference model
  bit            m_awvalid;
  logic [AW-1:0] m_awaddr;
  logic [LW-1:0] m_awlen;
  int            m_lens[$];     // outstanding burst lengths, oldest first
  int            m_beat;        // beats already accepted of the oldest burst
  bit            m_done;

  // Observed DUT events
  int aw_hs_seen;
  int w_hs_seen;
  int wlast_seen;
  int last_idx;
  int done_seen;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    aw_hs_seen = 0;
    w_hs_seen  = 0;
    wlast_seen = 0;
    last_idx   = 0;
    done_seen  = 0;
  endtask

  task automatic model_reset();
    m_awvalid = 1'b0;
    m_awaddr  = '0;
    m_awlen   = '0;
    m_lens.delete();
    m_beat    = 0;
    m_done    = 1'b0;
    cmd_src_q.delete();
    exp_data_q.delete();
    preset_q.delete();
    src_have  = 1'b0;
  endtask

  // One clock cycle: drive inputs shortly after the rising edge, compare all
  // outputs against the model, advance the model, then wait for the next edge.
  task automatic cycle();
    bit e_empty, e_full, e_cmd_ready, e_wvalid, e_wlast, e_src_ready, e_busy;
    bit cmd_acc, w_hs, w_last_hs;

    if (cmd_src_q.size() > 0) begin
      bus.CMD_VALID = 1'b1;
      bus.CMD_ADDR  = cmd_src_q[0].addr;
      bus.CMD_LEN   = cmd_src_q[0].len;
    end else begin
      bus.CMD_VALID = 1'b0;
    end

    if (src_en && ($urandom_range(99) < src_pct)) begin
      if (!src_have) begin
        if (preset_q.size() > 0) src_cur = preset_q.pop_front();
        else                     src_cur = $urandom();
        src_have = 1'b1;
        exp_data_q.push_back(src_cur);
      end
      bus.SRC_VALID = 1'b1;
      bus.SRC_DATA  = src_cur;
    end else begin
      bus.SRC_VALID = 1'b0;
      bus.SRC_DATA  = $urandom();
    end

    bus.INNER_AWREADY = awready_val;
    bus.INNER_WREADY  = (wready_mode == 2) ? cyc[0] : (wready_mode == 1);
    #1;

    e_empty     = (m_lens.size() == 0);
    e_full      = (m_lens.size() == QSIZE);
    e_cmd_ready = (!m_awvalid || awready_val) && !e_full;
    e_wvalid    = bus.SRC_VALID && !e_empty;
    e_wlast     = 1'b0;
    if (!e_empty) e_wlast = (m_beat == m_lens[0]);
    e_src_ready = bus.INNER_WREADY && !e_empty;
    e_busy      = m_awvalid || !e_empty;

    chk("cmd_ready", bus.CMD_READY,     e_cmd_ready);
    chk("awvalid",   bus.INNER_AWVALID, m_awvalid);
    chk("awaddr",    bus.INNER_AWADDR,  m_awaddr);
    chk("awlen",     bus.INNER_AWLEN,   m_awlen);
    chk("wvalid",    bus.INNER_WVALID,  e_wvalid);
    chk("wlast",     bus.INNER_WLAST,   e_wlast);
    chk("src_ready", bus.SRC_READY,     e_src_ready);
    chk("cmd_done",  bus.CMD_DONE,      m_done);
    chk("busy",      bus.BUSY,          e_busy);
    chk("wdata",     bus.INNER_WDATA,   bus.SRC_DATA);

    if (bus.INNER_AWVALID === 1'b1 && bus.INNER_AWREADY === 1'b1) aw_hs_seen++;
    if (bus.CMD_DONE === 1'b1) done_seen++;
    if (bus.INNER_WVALID === 1'b1 && bus.INNER_WREADY === 1'b1) begin
      w_hs_seen++;
      if (bus.INNER_WLAST === 1'b1) begin
        wlast_seen++;
        last_idx = w_hs_seen;
      end
    end

    cmd_acc   = bus.CMD_VALID && e_cmd_ready;
    w_hs      = e_wvalid && bus.INNER_WREADY;
    w_last_hs = w_hs && e_wlast;

    m_done = w_last_hs;
    if (w_hs) begin
      if (exp_data_q.size() > 0) begin
        chk("wdata_order", bus.INNER_WDATA, exp_data_q[0]);
        exp_data_q.delete(0);
      end
      src_have = 1'b0;
      if (w_last_hs) begin
        m_lens.delete(0);
        m_beat = 0;
      end else begin
        m_beat++;
      end
    end
    if (cmd_acc) begin
      m_lens.push_back(int'(bus.CMD_LEN));
      m_awvalid = 1'b1;
      m_awaddr  = bus.CMD_ADDR;
      m_awlen   = bus.CMD_LEN;
      cmd_src_q.delete(0);
    end else if (awready_val) begin
      m_awvalid = 1'b0;
    end

    @(posedge ACLK);
    #1;
    cyc++;
  endtask

  // Run until all commands have been issued and fully written (bounded).
  task automatic drain(input string tag, input int bound);
    bit idle;
    for (int i = 0; i < bound; i++) begin
      idle = (cmd_src_q.size() == 0) && (m_lens.size() == 0) && !m_awvalid && !m_done;
      if (idle) break;
      cycle();
    end
    idle = (cmd_src_q.size() == 0) && (m_lens.size() == 0) && !m_awvalid && !m_done;
    chk({tag, "_drained"}, idle, 1'b1);
    chk({tag, "_idle_busy"}, bus.BUSY, 1'b0);
  endtask

  initial begin
    cyc          = 0;
    src_en       = 1'b0;
    src_pct      = 100;
    awready_val  = 1'b0;
    wready_mode  = 0;
    bus.CMD_VALID     = 1'b0;
    bus.CMD_ADDR      = '0;
    bus.CMD_LEN       = '0;
    bus.SRC_VALID     = 1'b0;
    bus.SRC_DATA      = '0;
    bus.INNER_AWREADY = 1'b0;
    bus.INNER_WREADY  = 1'b0;
    model_reset();
    clear_obs();

    // Reset state
    repeat (2) @(posedge ACLK);
    #1;
    cycle();
    cycle();
    ARESETN = 1'b1;

    // Single command, 4 beats, all ready
    awready_val = 1'b1;
    wready_mode = 1;
    src_en      = 1'b1;
    src_pct     = 100;
    preset_q.push_back(32'hAA);
    preset_q.push_back(32'hBB);
    preset_q.push_back(32'hCC);
    preset_q.push_back(32'hDD);
    cmd_src_q.push_back('{addr: 32'h1000, len: 16'd3});
    clear_obs();
    drain("single", 50);
    chk("single_aw_hs",    aw_hs_seen, 1);
    chk("single_w_beats",  w_hs_seen,  4);
    chk("single_wlast_n",  wlast_seen, 1);
    chk("single_last_idx", last_idx,   4);
    chk("single_done_n",   done_seen,  1);

    // Queue full: W blocked, five single-beat commands
    src_en      = 1'b0;
    wready_mode = 0;
    for (int i = 0; i < 5; i++) cmd_src_q.push_back('{addr: 32'h2000 + 32'(i * 64), len: 16'd0});
    clear_obs();
    repeat (7) cycle();
    chk("qfull_cmd_ready", bus.CMD_READY, 1'b0);
    chk("qfull_accepts",   aw_hs_seen,    4);
    wready_mode = 1;
    src_en      = 1'b1;
    drain("qfull", 60);
    chk("qfull_w_beats", w_hs_seen,  5);
    chk("qfull_wlast_n", wlast_seen, 5);
    chk("qfull_done_n",  done_seen,  5);

    // Backpressure: toggling WREADY, random source valid
    wready_mode = 2;
    src_pct     = 60;
    cmd_src_q.push_back('{addr: $urandom(), len: 16'd7});
    clear_obs();
    drain("bp", 300);
    chk("bp_w_beats",  w_hs_seen,  8);
    chk("bp_wlast_n",  wlast_seen, 1);
    chk("bp_last_idx", last_idx,   8);

    // AW stall with a second command pending
    wready_mode = 1;
    src_pct     = 100;
    awready_val = 1'b0;
    cmd_src_q.push_back('{addr: 32'h3000, len: 16'd3});
    cmd_src_q.push_back('{addr: 32'h4000, len: 16'd3});
    clear_obs();
    repeat (10) cycle();
    chk("stall_cmd_ready", bus.CMD_READY,    1'b0);
    chk("stall_awaddr",    bus.INNER_AWADDR, 32'h3000);
    chk("stall_awlen",     bus.INNER_AWLEN,  16'd3);
    chk("stall_w_beats",   w_hs_seen,        4);
    awready_val = 1'b1;
    drain("stall", 60);
    chk("stall_total_beats", w_hs_seen, 8);

    // Reset in the middle of a 16-beat burst with AW still pending
    awready_val = 1'b0;
    cmd_src_q.push_back('{addr: 32'h5000, len: 16'd15});
    clear_obs();
    for (int i = 0; i < 30 && w_hs_seen < 5; i++) cycle();
    chk("rst_reached_beat5", w_hs_seen, 5);
    #2;
    ARESETN = 1'b0;
    #1;
    chk("rst_awvalid",   bus.INNER_AWVALID, 1'b0);
    chk("rst_awaddr",    bus.INNER_AWADDR,  '0);
    chk("rst_awlen",     bus.INNER_AWLEN,   '0);
    chk("rst_wvalid",    bus.INNER_WVALID,  1'b0);
    chk("rst_wlast",     bus.INNER_WLAST,   1'b0);
    chk("rst_src_ready", bus.SRC_READY,     1'b0);
    chk("rst_cmd_done",  bus.CMD_DONE,      1'b0);
    chk("rst_busy",      bus.BUSY,          1'b0);
    model_reset();
    src_en = 1'b0;
    @(posedge ACLK);
    #1;
    cycle();
    cycle();
    ARESETN     = 1'b1;
    awready_val = 1'b1;
    src_en      = 1'b1;
    cmd_src_q.push_back('{addr: 32'h6000, len: 16'd1});
    clear_obs();
    drain("post_rst", 40);
    chk("post_rst_w_beats",  w_hs_seen,  2);
    chk("post_rst_last_idx", last_idx,   2);
    chk("post_rst_wlast_n",  wlast_seen, 1);

    // Maximum burst length
    cmd_src_q.push_back('{addr: 32'h7000, len: 16'hFFFF});
    clear_obs();
    drain("max", 70000);
    chk("max_w_beats",  w_hs_seen,  65536);
    chk("max_wlast_n",  wlast_seen, 1);
    chk("max_last_idx", last_idx,   65536);
    chk("max_done_n",   done_seen,  1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
